// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-input round-robin stream arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_A = 2'd1,
        ST_GRANT_B = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux2_arb_mux2_wide.sv
// Parameterised 2:1 mux; picks i_b when i_sel is high.
module mux2_wide #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y_c
);

    assign o_y_c = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Packet-locked round-robin arbiter sharing one registered output stream
// between two valid/ready sources.
module mux2_stream_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    output logic             y_src,
    input  logic             y_ready,
    output logic             select,
    output logic             err
);

    // Counter must be able to hold MAX_BEATS+1, the saturation value.
    localparam int unsigned       CNT_W   = $clog2(MAX_BEATS + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(MAX_BEATS + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio;
    logic             w_prio_nxt;
    logic             r_select;
    logic             w_select_nxt;
    logic             r_y_valid;
    logic [WIDTH-1:0] r_y_data;
    logic             r_y_last;
    logic             r_y_src;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_take;
    logic             w_a_ready;
    logic             w_b_ready;
    logic             w_acc;
    logic [WIDTH:0]   w_mux;
    logic             w_beat_last;

    // Output slot is free when empty or being drained this cycle.
    assign w_take    = !r_y_valid || y_ready;
    assign w_a_ready = (r_state == ST_GRANT_A) && w_take;
    assign w_b_ready = (r_state == ST_GRANT_B) && w_take;
    assign w_acc     = (a_valid && w_a_ready) || (b_valid && w_b_ready);

    mux2_wide #(
        .WIDTH (WIDTH + 1)
    ) u_mux (
        .i_sel (r_select),
        .i_a   ({a_data, a_last}),
        .i_b   ({b_data, b_last}),
        .o_y_c (w_mux)
    );

    assign w_beat_last = w_mux[0];

    // Next-state: round-robin on ties, hold the grant until the last beat.
    always_comb begin
        w_state_nxt  = r_state;
        w_prio_nxt   = r_prio;
        w_select_nxt = r_select;
        case (r_state)
            ST_IDLE: begin
                if (a_valid && (!b_valid || r_prio == SRC_B)) begin
                    w_state_nxt  = ST_GRANT_A;
                    w_prio_nxt   = SRC_A;
                    w_select_nxt = SRC_A;
                end else if (b_valid) begin
                    w_state_nxt  = ST_GRANT_B;
                    w_prio_nxt   = SRC_B;
                    w_select_nxt = SRC_B;
                end
            end
            ST_GRANT_A: begin
                if (a_valid && w_a_ready && a_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT_B: begin
                if (b_valid && w_b_ready && b_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_prio   <= SRC_B;
            r_select <= SRC_A;
        end else begin
            r_state  <= w_state_nxt;
            r_prio   <= w_prio_nxt;
            r_select <= w_select_nxt;
        end
    end

    // Output register, beat counter and sticky overlong flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_y_last  <= 1'b0;
            r_y_src   <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_acc) begin
                r_y_valid <= 1'b1;
                r_y_data  <= w_mux[WIDTH:1];
                r_y_last  <= w_beat_last;
                r_y_src   <= r_select;
                if (w_beat_last) begin
                    r_cnt <= '0;
                end else begin
                    if (r_cnt >= CNT_MAX) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt != CNT_SAT) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end else if (y_ready) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign a_ready = w_a_ready;
    assign b_ready = w_b_ready;
    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;
    assign y_last  = r_y_last;
    assign y_src   = r_y_src;
    assign select  = r_select;
    assign err     = r_err;

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Directed self-checking bench for mux2_stream_arbiter (MAX_BEATS = 4).
module tb_mux2_stream_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0;
    logic [7:0] a_data = '0;
    logic       a_last = 1'b0;
    logic       a_ready;
    logic       b_valid = 1'b0;
    logic [7:0] b_data = '0;
    logic       b_last = 1'b0;
    logic       b_ready;
    logic       y_valid;
    logic [7:0] y_data;
    logic       y_last;
    logic       y_src;
    logic       y_ready = 1'b1;
    logic       select;
    logic       err;

    logic       a_en = 1'b0;
    logic       b_en = 1'b0;
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [9:0] mq[$];

    int n_checks = 0;
    int n_fail   = 0;

    mux2_stream_arbiter #(
        .WIDTH     (8),
        .MAX_BEATS (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_last  (b_last),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_last  (y_last),
        .y_src   (y_src),
        .y_ready (y_ready),
        .select  (select),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (mq.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(mq.size()), 32'(n));
    endtask

    // Source A producer: presents the queue head, pops on handshake.
    always begin : prod_a
        logic fire;
        @(negedge clk);
        fire = !rst && a_valid && a_ready;
        @(posedge clk);
        #2;
        if (fire && qa.size() > 0) void'(qa.pop_front());
        if (a_en && qa.size() > 0) begin
            a_valid = 1'b1;
            {a_last, a_data} = qa[0];
        end else begin
            a_valid = 1'b0;
            a_last  = 1'b0;
            a_data  = '0;
        end
    end

    always begin : prod_b
        logic fire;
        @(negedge clk);
        fire = !rst && b_valid && b_ready;
        @(posedge clk);
        #2;
        if (fire && qb.size() > 0) void'(qb.pop_front());
        if (b_en && qb.size() > 0) begin
            b_valid = 1'b1;
            {b_last, b_data} = qb[0];
        end else begin
            b_valid = 1'b0;
            b_last  = 1'b0;
            b_data  = '0;
        end
    end

    // Sink monitor: records {src, last, data} of every beat taken.
    always @(negedge clk) begin
        if (!rst && y_valid && y_ready) mq.push_back({y_src, y_last, y_data});
    end

    initial begin
        logic       yv[8];
        logic [7:0] yd[8];
        logic       ys[8];
        logic       sl[8];
        logic       ar[8];
        int         acc;
        int         at_cnt;
        int         k;
        logic       seen;

        // Reset held for two cycles, then three idle cycles.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq($sformatf("rst_hold_%0d", i),
                     32'({y_valid, y_last, y_src, select, err, a_ready, b_ready, y_data}), 32'd0);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("idle_%0d", i),
                     32'({y_valid, y_last, y_src, select, err, a_ready, b_ready, y_data}), 32'd0);
            tick();
        end

        // Tie break: A wins first, then B, then A again, one bubble apart.
        qa.push_back({1'b1, 8'h11});
        qa.push_back({1'b1, 8'h11});
        qb.push_back({1'b1, 8'h22});
        a_en = 1'b1;
        b_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            yv[i] = y_valid; yd[i] = y_data; ys[i] = y_src; sl[i] = select; ar[i] = a_ready;
        end
        check_eq("tie_grant_latency", 32'(ar[0]), 32'd0);
        check_eq("tie_a_ready", 32'(ar[1]), 32'd1);
        check_eq("tie_beat0", 32'({yv[2], ys[2], yd[2]}), 32'h211);
        check_eq("tie_bubble0", 32'(yv[3]), 32'd0);
        check_eq("tie_sel_b", 32'(sl[3]), 32'd1);
        check_eq("tie_sel_hold_idle", 32'(sl[4]), 32'd1);
        check_eq("tie_beat1", 32'({yv[4], ys[4], yd[4]}), 32'h322);
        check_eq("tie_bubble1", 32'(yv[5]), 32'd0);
        check_eq("tie_beat2", 32'({yv[6], ys[6], yd[6]}), 32'h211);
        tick();
        a_en = 1'b0;
        b_en = 1'b0;
        repeat (3) tick();

        // Packet lock: B waits until A's 3-beat packet completes.
        mq.delete();
        qa.push_back({1'b0, 8'h01});
        qa.push_back({1'b0, 8'h02});
        qa.push_back({1'b1, 8'h03});
        qb.push_back({1'b1, 8'h44});
        a_en = 1'b1;
        tick();
        b_en = 1'b1;
        wait_beats(4, 40, "lock_count");
        if (mq.size() >= 4) begin
            check_eq("lock_b0", 32'(mq[0]), 32'h001);
            check_eq("lock_b1", 32'(mq[1]), 32'h002);
            check_eq("lock_b2", 32'(mq[2]), 32'h103);
            check_eq("lock_b3", 32'(mq[3]), 32'h344);
        end
        a_en = 1'b0;
        b_en = 1'b0;
        repeat (3) tick();

        // Backpressure: sink stalls 4 cycles after the first beat lands.
        mq.delete();
        qa.push_back({1'b0, 8'h31});
        qa.push_back({1'b0, 8'h32});
        qa.push_back({1'b1, 8'h33});
        a_en = 1'b1;
        tick();
        tick();
        y_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("bp_hold_%0d", i), 32'({y_valid, a_ready, y_data}), 32'h231);
            tick();
        end
        y_ready = 1'b1;
        wait_beats(3, 30, "bp_count");
        if (mq.size() >= 3) begin
            check_eq("bp_b0", 32'(mq[0]), 32'h031);
            check_eq("bp_b1", 32'(mq[1]), 32'h032);
            check_eq("bp_b2", 32'(mq[2]), 32'h133);
        end
        repeat (5) tick();
        check_eq("bp_no_dup", 32'(mq.size()), 32'd3);
        a_en = 1'b0;

        // Overlong packet: 6 beats with MAX_BEATS = 4; err after beat 5.
        mq.delete();
        for (int i = 1; i <= 6; i++) qa.push_back({(i == 6) ? 1'b1 : 1'b0, 8'(8'h50 + i)});
        check_eq("ovl_err_before", 32'(err), 32'd0);
        a_en = 1'b1;
        acc = 0;
        at_cnt = -1;
        seen = 1'b0;
        k = 0;
        while (mq.size() < 6 && k < 60) begin
            @(negedge clk);
            if (err && !seen) begin
                seen = 1'b1;
                at_cnt = acc;
            end
            if (!rst && a_valid && a_ready) acc++;
            tick();
            k++;
        end
        check_eq("ovl_count", 32'(mq.size()), 32'd6);
        check_eq("ovl_err_after_beat", 32'(at_cnt), 32'd5);
        if (mq.size() >= 6) begin
            check_eq("ovl_b4", 32'(mq[4]), 32'h055);
            check_eq("ovl_b5", 32'(mq[5]), 32'h156);
        end
        repeat (3) tick();
        check_eq("ovl_err_sticky", 32'(err), 32'd1);
        a_en = 1'b0;
        repeat (2) tick();

        // Reset mid-packet after beat 2 of 4, then a fresh B packet.
        mq.delete();
        for (int i = 1; i <= 4; i++) qa.push_back({(i == 4) ? 1'b1 : 1'b0, 8'(8'h60 + i)});
        a_en = 1'b1;
        acc = 0;
        k = 0;
        while (acc < 2 && k < 20) begin
            @(negedge clk);
            if (!rst && a_valid && a_ready) acc++;
            tick();
            k++;
        end
        check_eq("rst_mid_beats", 32'(acc), 32'd2);
        rst = 1'b1;
        a_en = 1'b0;
        qa.delete();
        tick();
        rst = 1'b0;
        mq.delete();
        qb.push_back({1'b0, 8'h71});
        qb.push_back({1'b1, 8'h72});
        b_en = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_clear",
                 32'({y_valid, select, err, a_ready, b_ready}), 32'd0);
        tick();
        @(negedge clk);
        check_eq("rst_b_grant", 32'({b_ready, select}), 32'h3);
        wait_beats(2, 20, "rst_b_count");
        if (mq.size() >= 2) begin
            check_eq("rst_b0", 32'(mq[0]), 32'h271);
            check_eq("rst_b1", 32'(mq[1]), 32'h372);
        end
        b_en = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
